// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - op encodings, FSM states and width default for the multiply/divide unit
package mdu_pkg;

   localparam int MDU_DATA_SIZE = 32;

   typedef enum logic [1:0] {
      MDU_MULT  = 2'b00,
      MDU_MULTU = 2'b01,
      MDU_DIV   = 2'b10,
      MDU_DIVU  = 2'b11
   } mdu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } mdu_state_t;

endpackage

// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - request/result bundle between control unit and multiply/divide unit
interface mult_div_unit_if
   import mdu_pkg::*;
#(
   parameter int DATA_SIZE = MDU_DATA_SIZE
);
   logic                 start;
   logic [1:0]           op;
   logic [DATA_SIZE-1:0] SrcA;
   logic [DATA_SIZE-1:0] SrcB;
   logic                 busy;
   logic                 done;
   logic [DATA_SIZE-1:0] hi;
   logic [DATA_SIZE-1:0] lo;
   logic                 div_by_zero;

   modport master (
      output start, op, SrcA, SrcB,
      input  busy, done, hi, lo, div_by_zero
   );

   modport slave (
      input  start, op, SrcA, SrcB,
      output busy, done, hi, lo, div_by_zero
   );
endinterface

// File: rtl/mdu_sign_fix.sv
// rtl/mdu_sign_fix.sv - conditional two's-complement negation for operand magnitudes and results
module mdu_sign_fix #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_val,
   input  logic             i_neg,
   output logic [WIDTH-1:0] o_val
);
   assign o_val = i_neg ? -i_val : i_val;
endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit producing hi/lo over DATA_SIZE+2 cycles
// The divider datapath and divide-by-zero result are compiled in only when MDU_DIV_EN is defined.
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int DATA_SIZE = MDU_DATA_SIZE,
   parameter int CNT_WIDTH = 6
) (
   input  logic           CLK,
   input  logic           RST,
   mult_div_unit_if.slave bus
);
   localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(DATA_SIZE - 1);

   mdu_state_t               r_state;
   mdu_state_t               w_state_next;
   logic [CNT_WIDTH-1:0]     r_cnt;
   logic [2*DATA_SIZE-1:0]   r_acc;
   logic [DATA_SIZE-1:0]     r_opb;
   logic [DATA_SIZE-1:0]     r_hi;
   logic [DATA_SIZE-1:0]     r_lo;
   logic                     r_neg_res;
   logic                     r_dbz;

   mdu_op_t                  w_op;
   logic                     w_op_signed;
   logic                     w_op_div;
   logic                     w_a_neg;
   logic                     w_b_neg;
   logic                     w_accept;
   logic                     w_dbz_start;
   logic [DATA_SIZE-1:0]     w_mag_a;
   logic [DATA_SIZE-1:0]     w_mag_b;
   logic [DATA_SIZE:0]       w_sum;
   logic [2*DATA_SIZE-1:0]   w_mul_next;
   logic [2*DATA_SIZE-1:0]   w_prod_fix;

   assign w_op        = mdu_op_t'(bus.op);
   assign w_op_signed = (w_op == MDU_MULT) || (w_op == MDU_DIV);
   assign w_op_div    = (w_op == MDU_DIV) || (w_op == MDU_DIVU);
   assign w_a_neg     = w_op_signed && bus.SrcA[DATA_SIZE-1];
   assign w_b_neg     = w_op_signed && bus.SrcB[DATA_SIZE-1];
   assign w_accept    = bus.start && ((r_state == IDLE) || (r_state == DONE));

   mdu_sign_fix #(.WIDTH(DATA_SIZE)) u_mag_a (.i_val(bus.SrcA), .i_neg(w_a_neg), .o_val(w_mag_a));
   mdu_sign_fix #(.WIDTH(DATA_SIZE)) u_mag_b (.i_val(bus.SrcB), .i_neg(w_b_neg), .o_val(w_mag_b));
   mdu_sign_fix #(.WIDTH(2*DATA_SIZE)) u_prod (.i_val(r_acc), .i_neg(r_neg_res), .o_val(w_prod_fix));

   // Multiplier sits in the low half and is consumed LSB-first while the product grows in from the top.
   assign w_sum      = {1'b0, r_acc[2*DATA_SIZE-1:DATA_SIZE]} + {1'b0, r_opb};
   assign w_mul_next = r_acc[0] ? {w_sum, r_acc[DATA_SIZE-1:1]} : {1'b0, r_acc[2*DATA_SIZE-1:1]};

`ifdef MDU_DIV_EN
   logic                     r_is_div;
   logic                     r_neg_rem;
   logic [DATA_SIZE-1:0]     r_rem;
   logic [DATA_SIZE:0]       w_trial;
   logic                     w_ge;
   logic [DATA_SIZE-1:0]     w_diff;
   logic [DATA_SIZE-1:0]     w_quo_fix;
   logic [DATA_SIZE-1:0]     w_rem_fix;

   assign w_dbz_start = w_op_div && (bus.SrcB == '0);
   // The accepted remainder is always below the divisor, so only the trial value needs the extra bit.
   assign w_trial     = {r_rem, r_acc[DATA_SIZE-1]};
   assign w_ge        = w_trial >= {1'b0, r_opb};
   assign w_diff      = w_trial[DATA_SIZE-1:0] - r_opb;

   mdu_sign_fix #(.WIDTH(DATA_SIZE)) u_quo (.i_val(r_acc[DATA_SIZE-1:0]), .i_neg(r_neg_res), .o_val(w_quo_fix));
   mdu_sign_fix #(.WIDTH(DATA_SIZE)) u_rem (.i_val(r_rem), .i_neg(r_neg_rem), .o_val(w_rem_fix));
`else
   assign w_dbz_start = w_op_div;
`endif

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE, DONE: begin
            if (w_accept) begin
               w_state_next = w_dbz_start ? FIX : RUN;
            end else begin
               w_state_next = IDLE;
            end
         end
         RUN: begin
            if (r_cnt == LAST_ITER) begin
               w_state_next = FIX;
            end
         end
         FIX:     w_state_next = DONE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_cnt     <= '0;
         r_acc     <= '0;
         r_opb     <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_neg_res <= 1'b0;
         r_dbz     <= 1'b0;
`ifdef MDU_DIV_EN
         r_is_div  <= 1'b0;
         r_neg_rem <= 1'b0;
         r_rem     <= '0;
`endif
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (w_accept) begin
                  r_cnt     <= '0;
                  r_opb     <= w_mag_b;
                  r_neg_res <= w_a_neg ^ w_b_neg;
                  r_dbz     <= w_dbz_start;
                  // A zero divisor reports the raw dividend, so keep it unmodified in that case.
                  r_acc     <= {{DATA_SIZE{1'b0}}, (w_dbz_start ? bus.SrcA : w_mag_a)};
`ifdef MDU_DIV_EN
                  r_is_div  <= w_op_div;
                  r_neg_rem <= w_a_neg;
                  r_rem     <= '0;
`endif
               end
            end
            RUN: begin
               r_cnt <= r_cnt + CNT_WIDTH'(1);
`ifdef MDU_DIV_EN
               if (r_is_div) begin
                  r_rem                <= w_ge ? w_diff : w_trial[DATA_SIZE-1:0];
                  r_acc[DATA_SIZE-1:0] <= {r_acc[DATA_SIZE-2:0], w_ge};
               end else begin
                  r_acc <= w_mul_next;
               end
`else
               r_acc <= w_mul_next;
`endif
            end
            FIX: begin
               if (r_dbz) begin
`ifdef MDU_DIV_EN
                  r_hi <= r_acc[DATA_SIZE-1:0];
                  r_lo <= '1;
`else
                  r_hi <= '0;
                  r_lo <= '0;
`endif
               end else begin
`ifdef MDU_DIV_EN
                  if (r_is_div) begin
                     r_hi <= w_rem_fix;
                     r_lo <= w_quo_fix;
                  end else begin
                     {r_hi, r_lo} <= w_prod_fix;
                  end
`else
                  {r_hi, r_lo} <= w_prod_fix;
`endif
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy        = (r_state == RUN) || (r_state == FIX);
   assign bus.done        = (r_state == DONE);
   assign bus.div_by_zero = (r_state == DONE) && r_dbz;
   assign bus.hi          = r_hi;
   assign bus.lo          = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit with an arithmetic reference model
module tb_mult_div_unit;
   localparam int DS  = 32;
   localparam int LAT = DS + 1;

   logic CLK = 1'b0;
   logic RST = 1'b0;

   mult_div_unit_if #(.DATA_SIZE(DS)) bus ();

   mult_div_unit #(.DATA_SIZE(DS), .CNT_WIDTH(6)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   int edge_cnt = 0;
   always @(posedge CLK) edge_cnt++;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          acc_edge;
      int          done_edge;
   } txn_t;

   txn_t        q[$];
   int          rd_idx = 0;
   logic [31:0] exp_hi = '0;
   logic [31:0] exp_lo = '0;
   int          n_chk  = 0;
   int          n_fail = 0;

   task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      sa;
      longint      sb;
      logic [63:0] p;
`ifdef MDU_DIV_EN
      longint      qq;
      longint      rr;
`endif
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      model = '0;
      case (op)
         2'b00: begin p = 64'(sa * sb); model = {1'b0, p}; end
         2'b01: begin p = {32'b0, a} * {32'b0, b}; model = {1'b0, p}; end
         default: begin
`ifdef MDU_DIV_EN
            if (b == 32'd0) begin
               model = {1'b1, a, 32'hFFFF_FFFF};
            end else if (op == 2'b10) begin
               qq = sa / sb;
               rr = sa % sb;
               model = {1'b0, rr[31:0], qq[31:0]};
            end else begin
               model = {1'b0, a % b, a / b};
            end
`else
            model = {1'b1, 64'b0};
`endif
         end
      endcase
   endfunction

   function automatic int lat_of(input logic [1:0] op, input logic [31:0] b);
`ifdef MDU_DIV_EN
      if (op[1] && (b == 32'd0)) return 1;
`else
      if (op[1]) return 1;
`endif
      return LAT;
   endfunction

   always @(negedge CLK) begin : cmp
      logic        e_done;
      logic        e_busy;
      logic        e_dbz;
      logic [64:0] m;
      e_done = 1'b0;
      e_busy = 1'b0;
      e_dbz  = 1'b0;
      m      = '0;
      if (!RST) begin
         rd_idx = q.size();
         exp_hi = '0;
         exp_lo = '0;
      end else if (rd_idx < q.size()) begin
         if (q[rd_idx].done_edge == edge_cnt) begin
            e_done = 1'b1;
            m      = model(q[rd_idx].op, q[rd_idx].a, q[rd_idx].b);
            e_dbz  = m[64];
            exp_hi = m[63:32];
            exp_lo = m[31:0];
            rd_idx++;
         end else begin
            e_busy = (edge_cnt >= q[rd_idx].acc_edge);
         end
      end
      chk("cmp busy", 65'(bus.busy), 65'(e_busy));
      chk("cmp done", 65'(bus.done), 65'(e_done));
      chk("cmp div_by_zero", 65'(bus.div_by_zero), 65'(e_dbz));
      chk("cmp hi", 65'(bus.hi), 65'(exp_hi));
      chk("cmp lo", 65'(bus.lo), 65'(exp_lo));
   end

   task automatic step();
      @(posedge CLK);
      #2;
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit push, output int acc);
      txn_t t;
      bus.start = 1'b1;
      bus.op    = op;
      bus.SrcA  = a;
      bus.SrcB  = b;
      acc       = edge_cnt + 1;
      if (push) begin
         t.op        = op;
         t.a         = a;
         t.b         = b;
         t.acc_edge  = acc;
         t.done_edge = acc + lat_of(op, b);
         q.push_back(t);
      end
      step();
      bus.start = 1'b0;
      bus.op    = 2'($urandom);
      bus.SrcA  = $urandom;
      bus.SrcB  = $urandom;
   endtask

   task automatic wait_done_lit(input string nm, input int acc, input logic [31:0] ehi,
                                input logic [31:0] elo, input logic edbz, input int elat);
      bit          found;
      int          got;
      logic [31:0] h;
      logic [31:0] l;
      logic        z;
      found = 0; got = 0; h = '0; l = '0; z = 1'b0;
      for (int k = 0; k < DS + 10 && !found; k++) begin
         @(negedge CLK);
         if (bus.done) begin
            found = 1; got = edge_cnt; h = bus.hi; l = bus.lo; z = bus.div_by_zero;
         end
      end
      chk({nm, " done seen"}, 65'(found), 65'(1));
      chk({nm, " latency"}, 65'(got - acc), 65'(elat));
      chk({nm, " hi"}, 65'(h), 65'(ehi));
      chk({nm, " lo"}, 65'(l), 65'(elo));
      chk({nm, " div_by_zero"}, 65'(z), 65'(edbz));
      step();
   endtask

   task automatic run_lit(input string nm, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic edbz, input int elat);
      int acc;
      issue(op, a, b, 1'b1, acc);
      wait_done_lit(nm, acc, ehi, elo, edbz, elat);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, busy=%0b", bus.busy);
      $fatal(1);
   end

   initial begin
      int acc;
      int acc2;
      int done1;
      int seen;
      bus.start = 1'b0;
      bus.op    = 2'b00;
      bus.SrcA  = '0;
      bus.SrcB  = '0;

      chk("pin model mult", model(2'b00, 32'hFFFF_FFFD, 32'd5), {1'b0, 64'hFFFF_FFFF_FFFF_FFF1});
      chk("pin model multu", model(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF), {1'b0, 64'hFFFF_FFFE_0000_0001});
`ifdef MDU_DIV_EN
      chk("pin model div", model(2'b10, 32'hFFFF_FFF9, 32'd2), {1'b0, 64'hFFFF_FFFF_FFFF_FFFD});
      chk("pin model divu", model(2'b11, 32'd100, 32'd7), {1'b0, 64'h0000_0002_0000_000E});
      chk("pin model ovf", model(2'b10, 32'h8000_0000, 32'hFFFF_FFFF), {1'b0, 64'h0000_0000_8000_0000});
      chk("pin model dbz", model(2'b11, 32'h1234, 32'd0), {1'b1, 64'h0000_1234_FFFF_FFFF});
`else
      chk("pin model div off", model(2'b10, 32'hFFFF_FFF9, 32'd2), {1'b1, 64'h0});
`endif

      repeat (3) step();
      RST = 1'b1;
      step();

      run_lit("mult -3*5", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, LAT);
      run_lit("multu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, LAT);
      run_lit("mult minint^2", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, LAT);
      run_lit("mult minint*1", 2'b00, 32'h8000_0000, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, LAT);

      // divide then divide again from the DONE cycle
      issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, acc);
      done1 = acc + lat_of(2'b10, 32'd2);
      while (edge_cnt < done1) step();
`ifdef MDU_DIV_EN
      chk("div -7/2 done", 65'(bus.done), 65'(1));
      chk("div -7/2 hi", 65'(bus.hi), 65'(32'hFFFF_FFFF));
      chk("div -7/2 lo", 65'(bus.lo), 65'(32'hFFFF_FFFD));
      issue(2'b11, 32'd100, 32'd7, 1'b1, acc2);
      wait_done_lit("divu 100/7 b2b", acc2, 32'd2, 32'd14, 1'b0, LAT);
      run_lit("divu 0x1234/0", 2'b11, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, 1'b1, 1);
      run_lit("div ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, LAT);
      run_lit("div 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, LAT);
      run_lit("div -7/-2", 2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3, 1'b0, LAT);
`else
      chk("div off done", 65'(bus.done), 65'(1));
      chk("div off dbz", 65'(bus.div_by_zero), 65'(1));
      issue(2'b11, 32'd100, 32'd7, 1'b1, acc2);
      wait_done_lit("divu off b2b", acc2, 32'd0, 32'd0, 1'b1, 1);
      run_lit("divu 0x1234/0 off", 2'b11, 32'h1234, 32'd0, 32'd0, 32'd0, 1'b1, 1);
`endif

      // second start while busy must be ignored
      issue(2'b00, 32'd7, 32'd9, 1'b1, acc);
      repeat (3) step();
      bus.start = 1'b1;
      bus.op    = 2'b01;
      bus.SrcA  = 32'd3;
      bus.SrcB  = 32'd1000;
      step();
      bus.start = 1'b0;
      wait_done_lit("mult 7*9 ignore", acc, 32'd0, 32'd63, 1'b0, LAT);

      // reset mid-operation aborts and never reports
      issue(2'b01, 32'h1234, 32'h5678, 1'b1, acc);
      repeat (9) step();
      RST = 1'b0;
      #1;
      chk("rst busy", 65'(bus.busy), 65'(0));
      chk("rst done", 65'(bus.done), 65'(0));
      chk("rst hi", 65'(bus.hi), 65'(0));
      chk("rst lo", 65'(bus.lo), 65'(0));
      step();
      step();
      RST = 1'b1;
      seen = 0;
      for (int k = 0; k < 45; k++) begin
         @(negedge CLK);
         if (bus.done) seen++;
      end
      chk("rst no late done", 65'(seen), 65'(0));

      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
